// File: rtl/thres_cfg_master.sv
// Host-side initiator for the threshold / channel-hash / offset table port.
// Turns valid/ready commands into single-cycle table strobes and returns read data as responses.
module thres_cfg_master #(
   parameter int BITWIDTH = 32,
   parameter int DEPTH    = 256,
   parameter int TBL_NUM  = 3,
   parameter int LEN_W    = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [15:0]         cmd_addr,
   input  logic [BITWIDTH-1:0] cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [BITWIDTH-1:0] rsp_data,
   output logic [15:0]         rsp_addr,
   output logic                rsp_err,
   output logic                bram_we,
   output logic                bram_re,
   output logic [15:0]         bram_addr,
   output logic [BITWIDTH-1:0] bram_din,
   input  logic [BITWIDTH-1:0] bram_dout,
   output logic                busy,
   output logic [15:0]         err_cnt
);
   localparam logic [1:0]  OP_WRITE   = 2'b00;
   localparam logic [1:0]  OP_BURST   = 2'b10;
   localparam logic [1:0]  OP_VERIFY  = 2'b11;
   localparam logic [15:0] ADDR_LIMIT = 16'(TBL_NUM * DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT, S_RSP} state_t;
   state_t state_reg, state_next;

   logic [1:0]          op_reg, op_next;
   logic [15:0]         addr_reg, addr_next;
   logic [BITWIDTH-1:0] wdata_reg, wdata_next;
   logic [LEN_W-1:0]    remain_reg, remain_next;

   logic                cmd_ready_reg, cmd_ready_next;
   logic                rsp_valid_reg, rsp_valid_next;
   logic [BITWIDTH-1:0] rsp_data_reg, rsp_data_next;
   logic [15:0]         rsp_addr_reg, rsp_addr_next;
   logic                rsp_err_reg, rsp_err_next;
   logic                bram_we_reg, bram_we_next;
   logic                bram_re_reg, bram_re_next;
   logic [15:0]         bram_addr_reg, bram_addr_next;
   logic [BITWIDTH-1:0] bram_din_reg, bram_din_next;
   logic                busy_reg, busy_next;
   logic [15:0]         err_cnt_reg, err_cnt_next;

   logic             accept;
   logic             rsp_done;
   logic             more_words;
   logic [15:0]      addr_inc;
   logic [LEN_W-1:0] cmd_len;

   assign accept     = (state_reg == S_IDLE) && cmd_valid && cmd_ready_reg;
   assign rsp_done   = (state_reg == S_RSP) && rsp_valid_reg && rsp_ready;
   assign more_words = (op_reg == OP_BURST) && (remain_reg > LEN_W'(1));
   assign addr_inc   = addr_reg + 16'd1;
   assign cmd_len    = cmd_wdata[LEN_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         op_reg        <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         remain_reg    <= '0;
         cmd_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_addr_reg  <= '0;
         rsp_err_reg   <= 1'b0;
         bram_we_reg   <= 1'b0;
         bram_re_reg   <= 1'b0;
         bram_addr_reg <= '0;
         bram_din_reg  <= '0;
         busy_reg      <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         op_reg        <= op_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         remain_reg    <= remain_next;
         cmd_ready_reg <= cmd_ready_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_data_reg  <= rsp_data_next;
         rsp_addr_reg  <= rsp_addr_next;
         rsp_err_reg   <= rsp_err_next;
         bram_we_reg   <= bram_we_next;
         bram_re_reg   <= bram_re_next;
         bram_addr_reg <= bram_addr_next;
         bram_din_reg  <= bram_din_next;
         busy_reg      <= busy_next;
         err_cnt_reg   <= err_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               // A zero-length burst is accepted and silently dropped.
               if (cmd_op == OP_BURST && cmd_len == '0)
                  state_next = S_IDLE;
               else if (cmd_addr >= ADDR_LIMIT)
                  state_next = S_RSP;
               else if (cmd_op == OP_WRITE || cmd_op == OP_VERIFY)
                  state_next = S_WR;
               else
                  state_next = S_RD;
            end
         end
         S_WR:      state_next = (op_reg == OP_VERIFY) ? S_RD : S_IDLE;
         S_RD:      state_next = S_RD_WAIT;
         S_RD_WAIT: state_next = S_RSP;
         S_RSP: begin
            if (rsp_done) begin
               if (more_words)
                  state_next = (addr_inc < ADDR_LIMIT) ? S_RD : S_RSP;
               else
                  state_next = S_IDLE;
            end
         end
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      op_next        = op_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      remain_next    = remain_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_data_next  = rsp_data_reg;
      rsp_addr_next  = rsp_addr_reg;
      rsp_err_next   = rsp_err_reg;
      bram_we_next   = 1'b0;
      bram_re_next   = 1'b0;
      bram_addr_next = bram_addr_reg;
      bram_din_next  = bram_din_reg;
      err_cnt_next   = err_cnt_reg;
      cmd_ready_next = (state_next == S_IDLE);
      busy_next      = (state_next != S_IDLE);
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               op_next     = cmd_op;
               addr_next   = cmd_addr;
               wdata_next  = cmd_wdata;
               remain_next = (cmd_op == OP_BURST) ? cmd_len : LEN_W'(1);
               case (state_next)
                  S_WR: begin
                     bram_we_next   = 1'b1;
                     bram_addr_next = cmd_addr;
                     bram_din_next  = cmd_wdata;
                  end
                  S_RD: begin
                     bram_re_next   = 1'b1;
                     bram_addr_next = cmd_addr;
                  end
                  S_RSP: begin
                     rsp_valid_next = 1'b1;
                     rsp_err_next   = 1'b1;
                     rsp_data_next  = '0;
                     rsp_addr_next  = cmd_addr;
                  end
                  default: ;
               endcase
            end
         end
         S_WR: begin
            if (state_next == S_RD)
               bram_re_next = 1'b1;
         end
         S_RD_WAIT: begin
            // Table output is valid now, one cycle after the read strobe was sampled.
            rsp_valid_next = 1'b1;
            rsp_data_next  = bram_dout;
            rsp_addr_next  = addr_reg;
            rsp_err_next   = (op_reg == OP_VERIFY) && (bram_dout != wdata_reg);
         end
         S_RSP: begin
            if (rsp_done) begin
               rsp_valid_next = 1'b0;
               if (rsp_err_reg && err_cnt_reg != 16'hFFFF)
                  err_cnt_next = err_cnt_reg + 16'd1;
               if (state_next != S_IDLE) begin
                  addr_next   = addr_inc;
                  remain_next = remain_reg - LEN_W'(1);
               end
               if (state_next == S_RD) begin
                  bram_re_next   = 1'b1;
                  bram_addr_next = addr_inc;
               end
               if (state_next == S_RSP) begin
                  rsp_valid_next = 1'b1;
                  rsp_err_next   = 1'b1;
                  rsp_data_next  = '0;
                  rsp_addr_next  = addr_inc;
               end
            end
         end
         default: ;
      endcase
   end

   assign cmd_ready = cmd_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_addr  = rsp_addr_reg;
   assign rsp_err   = rsp_err_reg;
   assign bram_we   = bram_we_reg;
   assign bram_re   = bram_re_reg;
   assign bram_addr = bram_addr_reg;
   assign bram_din  = bram_din_reg;
   assign busy      = busy_reg;
   assign err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_thres_cfg_master.sv
// Bench for thres_cfg_master: table model on the BRAM port, expected-response queue built
// from the command semantics, one negedge monitor comparing every response and invariant.
module tb_thres_cfg_master;
   localparam int NWORDS = 768;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [15:0] rsp_addr;
   logic        rsp_err;
   logic        bram_we;
   logic        bram_re;
   logic [15:0] bram_addr;
   logic [31:0] bram_din;
   logic [31:0] bram_dout;
   logic        busy;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   thres_cfg_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .bram_we(bram_we), .bram_re(bram_re), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout),
      .busy(busy), .err_cnt(err_cnt)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] addr;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   rsp_t        mon_e;
   logic [31:0] ref_mem [NWORDS];
   logic [31:0] mem [NWORDS];
   logic        mem_ready = 1'b0;
   bit          stuck0 = 1'b0;
   bit          rand_ready = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          stall_until = 0;
   int          re_total = 0;
   int          we_total = 0;
   int          hs_total = 0;
   int          re_base, we_base;
   int          exp_re, exp_we;
   int          model_err = 0;

   function automatic logic [31:0] seed_word(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Table model: registered read, optional stuck-at-0 on bit 0 of the read path.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < NWORDS; i++) mem[i] <= seed_word(i);
         mem_ready <= 1'b1;
      end else begin
         if (bram_we && bram_addr < 16'(NWORDS)) mem[bram_addr[9:0]] <= bram_din;
         if (bram_re && bram_addr < 16'(NWORDS))
            bram_dout <= stuck0 ? (mem[bram_addr[9:0]] & ~32'd1) : mem[bram_addr[9:0]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response consumer driven independently of the command sequence.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cyc < stall_until)  rsp_ready = 1'b0;
         else if (rand_ready)    rsp_ready = ($urandom_range(0, 3) != 0);
         else                    rsp_ready = 1'b1;
      end
   end

   logic        rst_q = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] p_data;
   logic [15:0] p_addr;
   logic        p_err;

   always @(negedge clk) begin
      if (rst_n && rst_q) begin
         check("we_re_exclusive", 32'(bram_we & bram_re), 32'd0);
         check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
         if (bram_re) re_total++;
         if (bram_we) we_total++;
         if (bram_re || bram_we) check("strobe_in_range", 32'(bram_addr < 16'(NWORDS)), 32'd1);
         if (pend) begin
            check("rsp_held", 32'(rsp_valid), 32'd1);
            check("rsp_data_stable", rsp_data, p_data);
            check("rsp_addr_stable", 32'(rsp_addr), 32'(p_addr));
            check("rsp_err_stable", 32'(rsp_err), 32'(p_err));
         end
         if (rsp_valid && rsp_ready) begin
            hs_total++;
            $display("rsp addr=%0d data=0x%08h err=%0d err_cnt=%0d", rsp_addr, rsp_data, rsp_err, err_cnt);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got addr %0d, expected no response", rsp_addr);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_data", rsp_data, mon_e.data);
               check("rsp_addr", 32'(rsp_addr), 32'(mon_e.addr));
               check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
         end
         pend   = rsp_valid && !rsp_ready;
         p_data = rsp_data;
         p_addr = rsp_addr;
         p_err  = rsp_err;
      end else begin
         pend = 1'b0;
      end
      rst_q = rst_n;
   end

   task automatic push_word(input logic [15:0] a);
      rsp_t r;
      r.addr = a;
      if (a < 16'(NWORDS)) begin
         exp_re++;
         r.data = stuck0 ? (ref_mem[a[9:0]] & ~32'd1) : ref_mem[a[9:0]];
         r.err  = 1'b0;
      end else begin
         r.data = 32'd0;
         r.err  = 1'b1;
         if (model_err < 65535) model_err++;
      end
      exp_q.push_back(r);
   endtask

   task automatic model_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd);
      rsp_t r;
      exp_re = 0;
      exp_we = 0;
      case (op)
         2'b00: begin
            if (addr < 16'(NWORDS)) begin
               ref_mem[addr[9:0]] = wd;
               exp_we = 1;
            end else push_word(addr);
         end
         2'b01: push_word(addr);
         2'b10: for (int i = 0; i < int'(wd[9:0]); i++) push_word(addr + 16'(i));
         default: begin
            if (addr < 16'(NWORDS)) begin
               ref_mem[addr[9:0]] = wd;
               exp_we = 1;
               exp_re = 1;
               r.addr = addr;
               r.data = stuck0 ? (wd & ~32'd1) : wd;
               r.err  = (r.data != wd);
               if (r.err && model_err < 65535) model_err++;
               exp_q.push_back(r);
            end else push_word(addr);
         end
      endcase
   endtask

   // Returns at 1 time unit after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                        input bit use_model);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 within 200 cycles");
      end else begin
         cmd_op    = op;
         cmd_addr  = addr;
         cmd_wdata = wd;
         cmd_valid = 1'b1;
         re_base   = re_total;
         we_base   = we_total;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         $display("cmd op=%0d addr=%0d wdata=0x%08h", op, addr, wd);
         if (use_model) model_cmd(op, addr, wd);
      end
   endtask

   task automatic wait_done(output int busy_cycles);
      int t = 0;
      busy_cycles = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && t < 1000) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         t++;
      end
      check("done_in_time", 32'(t < 1000), 32'd1);
      check("rsp_count", 32'(exp_q.size()), 32'd0);
      check("re_strobes", 32'(re_total - re_base), 32'(exp_re));
      check("we_strobes", 32'(we_total - we_base), 32'(exp_we));
      check("err_cnt", 32'(err_cnt), 32'(model_err));
      exp_q.delete();
   endtask

   task automatic wait_rsp();
      int t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test, expected completion before 500000");
      $fatal(1, "global timeout");
   end

   initial begin
      int bc;
      int t;
      int hs_base;
      logic [1:0]  op;
      logic [15:0] a;
      logic [31:0] wd;

      for (int i = 0; i < NWORDS; i++) ref_mem[i] = seed_word(i);
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;

      // Reset values
      @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bram_we_re", 32'({bram_we, bram_re}), 32'd0);
      check("rst_bram_addr", 32'(bram_addr), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // WRITE 5 then READ 5 with exact latency
      issue(2'b00, 16'd5, 32'h0000_0190, 1'b1);
      wait_done(bc);
      check("write_busy_cycles", 32'(bc), 32'd1);
      issue(2'b01, 16'd5, 32'd0, 1'b1);
      @(negedge clk);
      check("read_re_c1", 32'(bram_re), 32'd1);
      check("read_addr_c1", 32'(bram_addr), 32'd5);
      check("read_valid_c1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("read_re_c2", 32'(bram_re), 32'd0);
      check("read_valid_c2", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("read_valid_c3", 32'(rsp_valid), 32'd1);
      check("read_data_lit", rsp_data, 32'h0000_0190);
      wait_done(bc);

      // Burst across the table bank boundary
      for (int i = 254; i < 258; i++) begin
         issue(2'b00, 16'(i), 32'hA000_0000 | 32'(i), 1'b1);
         wait_done(bc);
      end
      issue(2'b10, 16'd254, 32'd4, 1'b1);
      wait_done(bc);
      check("burst4_busy_cycles", 32'(bc), 32'd12);

      // Burst running off the end of the mapped range
      issue(2'b10, 16'd766, 32'd4, 1'b1);
      wait_done(bc);
      check("burst_oor_busy_cycles", 32'(bc), 32'd8);
      check("burst_oor_err_cnt_lit", 32'(err_cnt), 32'd2);

      // WRITE_VERIFY with a stuck read bit, then clean
      stuck0 = 1'b1;
      issue(2'b11, 16'd10, 32'h1234_5679, 1'b1);
      wait_rsp();
      check("verify_stuck_data_lit", rsp_data, 32'h1234_5678);
      check("verify_stuck_err_lit", 32'(rsp_err), 32'd1);
      wait_done(bc);
      check("verify_err_cnt_lit", 32'(err_cnt), 32'd3);
      stuck0 = 1'b0;
      issue(2'b11, 16'd11, 32'h1234_5679, 1'b1);
      wait_done(bc);
      check("verify_clean_err_cnt_lit", 32'(err_cnt), 32'd3);

      // Zero-length burst: no response, no strobes
      issue(2'b10, 16'd20, 32'd0, 1'b1);
      wait_done(bc);

      // Consumer stalls 10 cycles in the middle of a burst
      hs_base = hs_total;
      issue(2'b10, 16'd300, 32'd6, 1'b1);
      t = 0;
      while (hs_total < hs_base + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      stall_until = cyc + 11;
      wait_done(bc);
      check("stall_hs_count", 32'(hs_total - hs_base), 32'd6);

      // Reset while the read is waiting on table data
      issue(2'b01, 16'd5, 32'd0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_data", rsp_data, 32'd0);
      check("midrst_rsp_err", 32'(rsp_err), 32'd0);
      check("midrst_strobes", 32'({bram_we, bram_re}), 32'd0);
      check("midrst_bram_addr", 32'(bram_addr), 32'd0);
      check("midrst_bram_din", bram_din, 32'd0);
      check("midrst_err_cnt", 32'(err_cnt), 32'd0);
      model_err = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      issue(2'b01, 16'd5, 32'd0, 1'b1);
      wait_rsp();
      check("post_rst_read_lit", rsp_data, 32'h0000_0190);
      wait_done(bc);

      // Randomized commands with a random consumer
      rand_ready = 1'b1;
      for (int n = 0; n < 80; n++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(760, 775)) : 16'($urandom_range(0, 767));
         wd = (op == 2'b10) ? 32'($urandom_range(0, 6)) : $urandom;
         issue(op, a, wd, 1'b1);
         wait_done(bc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
